// File: rtl/peripheral_ahb3_spram_ws.sv
// AHB3-Lite single-port SRAM slave with read wait states, byte-lane writes,
// a pending-write buffer with read-after-write forwarding, and a two-cycle ERROR response.
module peripheral_ahb3_spram_ws #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned PLEN        = 64,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  localparam int unsigned NB        = XLEN / 8;
  localparam int unsigned BL        = $clog2(NB);
  localparam int unsigned AW        = $clog2(MEM_DEPTH);
  localparam int unsigned MEM_BYTES = MEM_DEPTH * NB;

  typedef enum logic [2:0] {
    DP_IDLE,
    DP_WRITE,
    DP_RWAIT,
    DP_READ,
    DP_ERR1,
    DP_ERR2
  } state_t;

  logic [XLEN-1:0] mem [MEM_DEPTH];

  state_t          state_q, state_d;
  logic            hready_d, hresp_d;
  logic [XLEN-1:0] hrdata_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            acc, a_err;
  logic [AW-1:0]   a_idx, dp_idx, pend_idx, fwd_idx;
  logic [BL-1:0]   a_off;
  logic [NB-1:0]   a_be, dp_be, pend_be;
  logic [7:0]      align_mask;
  logic [XLEN-1:0] pend_data, fwd_word;
  logic            pend_valid;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Address-phase decode
  assign acc        = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign a_idx      = HADDR[AW+BL-1:BL];
  assign a_off      = HADDR[BL-1:0];
  assign align_mask = 8'((9'd1 << HSIZE) - 9'd1);
  assign a_err      = (HADDR >= PLEN'(MEM_BYTES)) || (HSIZE > 3'(BL)) ||
                      ((HADDR[7:0] & align_mask) != 8'd0);

  always_comb begin
    a_be = '0;
    for (int i = 0; i < int'(NB); i++)
      a_be[i] = (i >= int'(a_off)) && (i < int'(a_off) + (1 << HSIZE));
  end

  // Read word: array, then older pending bytes, then in-flight HWDATA bytes
  always_comb begin
    fwd_idx  = (state_q == DP_RWAIT) ? dp_idx : a_idx;
    fwd_word = mem[fwd_idx];
    for (int i = 0; i < int'(NB); i++) begin
      if (pend_valid && (pend_idx == fwd_idx) && pend_be[i])
        fwd_word[8*i +: 8] = pend_data[8*i +: 8];
      if ((state_q == DP_WRITE) && (dp_idx == fwd_idx) && dp_be[i])
        fwd_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    hready_d = 1'b1;
    hresp_d  = 1'b0;
    hrdata_d = HRDATA;
    cnt_d    = cnt_q;
    case (state_q)
      DP_ERR1: begin
        state_d = DP_ERR2;
        hresp_d = 1'b1;
      end
      DP_RWAIT: begin
        if (cnt_q <= 2'd1) begin
          state_d  = DP_READ;
          hrdata_d = fwd_word;
        end else begin
          hready_d = 1'b0;
          cnt_d    = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = DP_IDLE;
        if (acc) begin
          if (a_err) begin
            state_d  = DP_ERR1;
            hready_d = 1'b0;
            hresp_d  = 1'b1;
          end else if (HWRITE) begin
            state_d = DP_WRITE;
          end else if (WAIT_STATES > 0) begin
            state_d  = DP_RWAIT;
            hready_d = 1'b0;
            cnt_d    = 2'(WAIT_STATES);
          end else begin
            state_d  = DP_READ;
            hrdata_d = fwd_word;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= DP_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      HREADYOUT <= hready_d;
      HRESP     <= hresp_d;
      HRDATA    <= hrdata_d;
      cnt_q     <= cnt_d;
    end
  end

  // Data-phase context and pending-write buffer; a held write commits on the next edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_idx     <= '0;
      dp_be      <= '0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_be    <= '0;
      pend_data  <= '0;
    end else begin
      if (acc) begin
        dp_idx <= a_idx;
        dp_be  <= a_be;
      end
      pend_valid <= (state_q == DP_WRITE);
      if (state_q == DP_WRITE) begin
        pend_idx  <= dp_idx;
        pend_be   <= dp_be;
        pend_data <= HWDATA;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (pend_valid) begin
      for (int i = 0; i < int'(NB); i++)
        if (pend_be[i]) mem[pend_idx][8*i +: 8] <= pend_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_peripheral_ahb3_spram_ws.sv
// Bench for peripheral_ahb3_spram_ws: two lanes (0 and 2 wait states), each with a
// driver, a byte-array reference model feeding a scoreboard queue, and a monitor.
module tb_peripheral_ahb3_spram_ws;

  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned MEM_BYTES = MEM_DEPTH * 8;

  typedef struct {
    int          kind;  // 1 write, 2 read, 3 error
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input int lane, input string nm, input logic [63:0] act,
                       input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL lane%0d %s actual=%h expected=%h t=%0t", lane, nm, act, exp_v, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned WS = g * 2;

    logic        rstn, hsel, hwrite, hmastlock, hreadyout, hresp, fin;
    logic [63:0] haddr, hwdata, hrdata, prev_wdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [7:0]  ref_mem [MEM_BYTES];
    exp_t        q[$];

    peripheral_ahb3_spram_ws #(
      .XLEN(64), .PLEN(64), .MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(WS)
    ) dut (
      .HCLK(clk), .HRESETn(rstn), .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(hrdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hreadyout),
      .HREADYOUT(hreadyout), .HRESP(hresp)
    );

    // Drive one address phase (and the previous data phase), update the model, wait for acceptance
    task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] sz, input logic [63:0] addr, input logic [63:0] wdata);
      exp_t e;
      bit   err;
      int   a, budget;
      hsel = sel; htrans = trans; hwrite = wr; hsize = sz; haddr = addr; hwdata = prev_wdata;
      hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
      if (sel && trans[1]) begin
        e.kind = 0;
        e.data = '0;
        err = (addr >= 64'(MEM_BYTES)) || (sz > 3'd3) || ((addr % (64'd1 << sz)) != 64'd0);
        a = int'(addr[11:0]);
        if (err) e.kind = 3;
        else if (wr) begin
          e.kind = 1;
          for (int b = 0; b < (1 << sz); b++) ref_mem[a + b] = wdata[8*((a + b) % 8) +: 8];
        end else begin
          e.kind = 2;
          for (int b = 0; b < 8; b++) e.data[8*b +: 8] = ref_mem[(a & ~7) + b];
        end
        q.push_back(e);
      end
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!hreadyout && budget < 20);
      if (!hreadyout) check(g, "accept_timeout", 64'(hreadyout), 64'd1);
      @(posedge clk);
      #1;
      prev_wdata = wdata;
    endtask

    initial begin
      logic [2:0]  sz;
      logic [63:0] a;
      int          r;
      fin = 1'b0; rstn = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
      haddr = '0; hwdata = '0; hburst = '0; hprot = '0; hmastlock = 1'b0; prev_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      for (int w = 0; w < int'(MEM_DEPTH); w++)
        xfer(1, 2'b10, 1, 3'd3, 64'(w * 8), {$urandom, $urandom});
      // Directed cases
      xfer(1, 2'b10, 1, 3'd3, 64'h10, 64'h0123456789ABCDEF);
      xfer(1, 2'b00, 0, 3'd0, 64'h0, 64'h0);
      xfer(1, 2'b10, 0, 3'd3, 64'h10, 64'h0);
      xfer(1, 2'b10, 1, 3'd0, 64'h13, 64'h00000000AA000000);
      xfer(1, 2'b00, 0, 3'd0, 64'h0, 64'h0);
      xfer(1, 2'b10, 0, 3'd3, 64'h10, 64'h0);
      xfer(1, 2'b10, 1, 3'd3, 64'h20, 64'hDEADBEEFCAFEF00D);
      xfer(1, 2'b10, 0, 3'd3, 64'h20, 64'h0);
      xfer(1, 2'b10, 1, 3'd3, 64'h800, 64'h1111111111111111);
      xfer(1, 2'b10, 0, 3'd3, 64'h0, 64'h0);
      xfer(1, 2'b10, 0, 3'd2, 64'h2, 64'h0);
      xfer(1, 2'b11, 1, 3'd4, 64'h0, 64'h2222222222222222);
      xfer(1, 2'b10, 1, 3'd0, 64'h7FF, 64'h5A00000000000000);
      xfer(1, 2'b10, 0, 3'd3, 64'h7F8, 64'h0);
      xfer(1, 2'b00, 1, 3'd3, 64'h30, 64'h3333333333333333);
      xfer(0, 2'b10, 1, 3'd3, 64'h30, 64'h4444444444444444);
      xfer(1, 2'b01, 1, 3'd3, 64'h30, 64'h5555555555555555);
      xfer(1, 2'b10, 0, 3'd3, 64'h30, 64'h0);
      // Reset while a read is in its data phase
      xfer(1, 2'b00, 0, 3'd0, 64'h0, 64'h0);
      xfer(1, 2'b10, 0, 3'd3, 64'h40, 64'h0);
      hsel = 1'b0; htrans = 2'b00;
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check(g, "rst_hreadyout", 64'(hreadyout), 64'd1);
      check(g, "rst_hresp", 64'(hresp), 64'd0);
      check(g, "rst_hrdata", hrdata, 64'd0);
      @(negedge clk);
      @(posedge clk);
      #1 rstn = 1'b1;
      xfer(1, 2'b10, 0, 3'd3, 64'h40, 64'h0);
      // Randomized traffic, mostly in a small window to exercise forwarding
      for (int i = 0; i < 300; i++) begin
        r  = $urandom_range(0, 15);
        sz = (r == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        a  = 64'($urandom_range(0, 127));
        if (r != 1 && sz <= 3'd3) a = a & ~((64'd1 << sz) - 64'd1);
        if (r == 2) a = 64'($urandom_range(2040, 2200));
        xfer($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom), sz, a,
             {$urandom, $urandom});
      end
      repeat (3) xfer(1, 2'b00, 0, 3'd0, 64'h0, 64'h0);
      fin = 1'b1;
    end

    // Monitor: pops one expectation per accepted address phase and checks its data phase
    initial begin
      bit          have;
      exp_t        cur;
      int          n;
      logic [63:0] last_rd;
      have = 0; n = 0; last_rd = '0;
      cur.kind = 0; cur.data = '0;
      forever begin
        @(negedge clk);
        if (!rstn) begin
          check(g, "reset_hreadyout", 64'(hreadyout), 64'd1);
          check(g, "reset_hresp", 64'(hresp), 64'd0);
          check(g, "reset_hrdata", hrdata, 64'd0);
          have = 0;
          last_rd = '0;
        end else begin
          if (have) begin
            n++;
            case (cur.kind)
              1: begin
                check(g, "wr_hreadyout", 64'(hreadyout), 64'd1);
                check(g, "wr_hresp", 64'(hresp), 64'd0);
                check(g, "wr_hrdata_hold", hrdata, last_rd);
              end
              2: begin
                check(g, "rd_hresp", 64'(hresp), 64'd0);
                if (n <= int'(WS)) begin
                  check(g, "rd_wait_hreadyout", 64'(hreadyout), 64'd0);
                  check(g, "rd_wait_hrdata_hold", hrdata, last_rd);
                end else begin
                  check(g, "rd_hreadyout", 64'(hreadyout), 64'd1);
                  check(g, "rd_hrdata", hrdata, cur.data);
                  last_rd = cur.data;
                end
              end
              default: begin
                check(g, "err_hresp", 64'(hresp), 64'd1);
                check(g, "err_hreadyout", 64'(hreadyout), (n == 1) ? 64'd0 : 64'd1);
              end
            endcase
            if (hreadyout || n > 6) have = 0;
          end else begin
            check(g, "idle_hreadyout", 64'(hreadyout), 64'd1);
            check(g, "idle_hresp", 64'(hresp), 64'd0);
            check(g, "idle_hrdata_hold", hrdata, last_rd);
          end
          if (hsel && htrans[1] && hreadyout) begin
            if (q.size() == 0) check(g, "scoreboard_empty", 64'd0, 64'd1);
            else begin
              cur  = q.pop_front();
              have = 1;
              n    = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(lane[0].fin && lane[1].fin) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (!(lane[0].fin && lane[1].fin)) begin
      checks++;
      failures++;
      $display("FAIL run_timeout actual=%0d cycles expected=completion", t);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
